pixel_fifo_param: RTL and testbench

Parametrised synchronous FIFO for pixel streams. It is the successor of the fixed 8-bit/16-entry pixel FIFO and sits between the line-buffer/feature-map producers and the convolution datapath.
- Adds: configurable width and depth, registered read port with a valid strobe, occupancy count, parametrised almost-full/almost-empty, full-with-read write acceptance, synchronous flush, and sticky error flags with explicit clear.

---
 rtl/pixel_fifo_pkg.sv | 14 +
 rtl/pixel_fifo_ram.sv | 27 ++
 rtl/pixel_fifo_param.sv | 91 +++++++++
 tb/tb_pixel_fifo_param.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pixel_fifo_pkg.sv
// Shared constants and helpers for the parametrised pixel FIFO.
// Optional high-water mark is enabled with the PIXEL_FIFO_PEAK_EN macro.
package pixel_fifo_pkg;
   localparam int PIX_DATA_W = 8;
   localparam int PIX_ADDR_W = 4;

   // Wrapping pointer difference masked to the pointer width (w <= 31).
   function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
      logic [31:0] mask;
      mask = (32'd1 << w) - 32'd1;
      return (a - b) & mask;
   endfunction
endpackage

// File: rtl/pixel_fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write, registered synchronous read.
// The read register resets to zero and holds when no read is issued; the array does not reset.
module pixel_fifo_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Same-address write and read in one cycle returns the old word (oldest entry when full).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/pixel_fifo_param.sv
// Parametrised synchronous pixel FIFO with occupancy flags, sticky errors and flush.
// Define PIXEL_FIFO_PEAK_EN to build the high-water-mark register behind peak_level.
module pixel_fifo_param
   import pixel_fifo_pkg::*;
#(
   parameter int DATA_W   = PIX_DATA_W,
   parameter int ADDR_W   = PIX_ADDR_W,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              clr_err,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow,
   output logic [ADDR_W:0]   peak_level
);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);

   logic [ADDR_W:0] wptr, rptr, wptr_nxt, rptr_nxt;
   logic            rd_acc, wr_acc, ovf_set, unf_set;

   // Flags derive only from registered pointers.
   assign count        = (ADDR_W+1)'(ptr_diff(32'(wptr), 32'(rptr), ADDR_W+1));
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (int'(count) >= AF_LEVEL);
   assign almost_empty = (int'(count) <= AE_LEVEL);

   // Flush masks both requests, so it neither moves pointers nor raises errors.
   assign rd_acc  = rd_en & ~empty & ~flush;
   assign wr_acc  = wr_en & (~full | rd_acc) & ~flush;
   assign ovf_set = wr_en & ~flush & ~wr_acc;
   assign unf_set = rd_en & ~flush & ~rd_acc;

   assign wptr_nxt = flush ? '0 : wptr + (ADDR_W+1)'(wr_acc);
   assign rptr_nxt = flush ? '0 : rptr + (ADDR_W+1)'(rd_acc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr      <= '0;
         rptr      <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wptr      <= wptr_nxt;
         rptr      <= rptr_nxt;
         rd_valid  <= rd_acc;
         // A set event in the same cycle as clr_err wins.
         overflow  <= ovf_set | (overflow & ~clr_err);
         underflow <= unf_set | (underflow & ~clr_err);
      end
   end

   pixel_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_acc),
      .waddr (wptr[ADDR_W-1:0]),
      .wdata (wr_data),
      .re    (rd_acc),
      .raddr (rptr[ADDR_W-1:0]),
      .rdata (rd_data)
   );

`ifdef PIXEL_FIFO_PEAK_EN
   logic [ADDR_W:0] count_nxt;
   assign count_nxt = (ADDR_W+1)'(ptr_diff(32'(wptr_nxt), 32'(rptr_nxt), ADDR_W+1));

   // clr_err restarts tracking from the post-edge occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  peak_level <= '0;
      else if (clr_err)            peak_level <= count_nxt;
      else if (count_nxt > peak_level) peak_level <= count_nxt;
   end
`else
   assign peak_level = '0;
`endif
endmodule

// File: tb/tb_pixel_fifo_param.sv
// Self-checking bench for pixel_fifo_param: directed plan steps plus random traffic vs a queue model.
module tb_pixel_fifo_param;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0, clr_err = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic [7:0] rd_data;
   logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0] count, peak_level;

   int tests = 0;
   int fails = 0;

   logic [7:0] q[$];
   logic [7:0] m_rd;
   bit         m_vld, m_ovf, m_unf;
   int         m_peak;

   pixel_fifo_param dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
      .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
      .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .underflow(underflow), .peak_level(peak_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_rd = 8'h00; m_vld = 0; m_ovf = 0; m_unf = 0; m_peak = 0;
   endtask

   task automatic check_all(input string where);
      int n;
      n = q.size();
      chk({where, ":count"}, 32'(count), n);
      chk({where, ":full"}, 32'(full), 32'(n == 16));
      chk({where, ":empty"}, 32'(empty), 32'(n == 0));
      chk({where, ":almost_full"}, 32'(almost_full), 32'(n >= 12));
      chk({where, ":almost_empty"}, 32'(almost_empty), 32'(n <= 2));
      chk({where, ":overflow"}, 32'(overflow), 32'(m_ovf));
      chk({where, ":underflow"}, 32'(underflow), 32'(m_unf));
      chk({where, ":rd_valid"}, 32'(rd_valid), 32'(m_vld));
      chk({where, ":rd_data"}, 32'(rd_data), 32'(m_rd));
`ifdef PIXEL_FIFO_PEAK_EN
      chk({where, ":peak"}, 32'(peak_level), m_peak);
`else
      chk({where, ":peak"}, 32'(peak_level), 0);
`endif
   endtask

   // One clock with the given inputs; the model advances from its pre-edge state.
   task automatic step(input string where, input bit wr, input logic [7:0] d, input bit rd,
                       input bit fl, input bit clr);
      bit emp, ful, racc, wacc, oset, uset;
      wr_en = wr; wr_data = d; rd_en = rd; flush = fl; clr_err = clr;
      @(posedge clk);
      #1;
      emp = (q.size() == 0);
      ful = (q.size() == 16);
      oset = 0; uset = 0;
      if (fl) begin
         q.delete();
         m_vld = 0;
      end else begin
         racc = rd && !emp;
         wacc = wr && (!ful || racc);
         oset = wr && !wacc;
         uset = rd && !racc;
         m_vld = racc;
         if (racc) m_rd = q.pop_front();
         if (wacc) q.push_back(d);
      end
      m_ovf = oset || (m_ovf && !clr);
      m_unf = uset || (m_unf && !clr);
      if (clr) m_peak = q.size();
      else if (q.size() > m_peak) m_peak = q.size();
      wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
      check_all(where);
   endtask

   task automatic do_reset();
      #1 rst_n = 0;
      #2;
      model_reset();
      check_all("reset");
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      model_reset();
      #2 check_all("reset_hold");
      @(negedge clk);
      rst_n = 1;

      // Fill with 0x01..0x10, then overflow attempt, then clear.
      for (int i = 1; i <= 16; i++) step("fill", 1, 8'(i), 0, 0, 0);
      step("ovf_write", 1, 8'hAA, 0, 0, 0);
      step("clr_ovf", 0, 8'h00, 0, 0, 1);
      // Full with simultaneous write and read.
      step("full_wr_rd", 1, 8'h55, 1, 0, 0);
      chk("full_wr_rd:first", 32'(rd_data), 32'h01);
      for (int i = 0; i < 15; i++) step("drain", 0, 8'h00, 1, 0, 0);
      step("drain_last", 0, 8'h00, 1, 0, 0);
      chk("drain_last:0x55", 32'(rd_data), 32'h55);
      // Empty reads.
      step("unf_read", 0, 8'h00, 1, 0, 0);
      step("empty_wr_rd", 1, 8'h7E, 1, 0, 0);
      step("read_7e", 0, 8'h00, 1, 0, 0);
      step("clr_err", 0, 8'h00, 0, 0, 1);
      // Flush with a concurrent write.
      for (int i = 0; i < 5; i++) step("pre_flush_wr", 1, 8'(8'h30 + i), 0, 0, 0);
      for (int i = 0; i < 2; i++) step("pre_flush_rd", 0, 8'h00, 1, 0, 0);
      step("flush_wr", 1, 8'hEE, 0, 1, 0);
      step("post_flush_rd", 0, 8'h00, 1, 0, 0);
      step("clr_err2", 0, 8'h00, 0, 0, 1);

      // Mid-operation reset drops pending data.
      for (int i = 0; i < 3; i++) step("pre_rst_wr", 1, 8'(8'hC0 + i), 0, 0, 0);
      do_reset();
      step("post_rst_wr", 1, 8'h99, 0, 0, 0);
      step("post_rst_rd", 0, 8'h00, 1, 0, 0);
      chk("post_rst_rd:data", 32'(rd_data), 32'h99);

      // High-water mark sequence.
      do_reset();
      for (int i = 0; i < 9; i++) step("peak_wr9", 1, 8'(i), 0, 0, 0);
      for (int i = 0; i < 9; i++) step("peak_rd9", 0, 8'h00, 1, 0, 0);
      for (int i = 0; i < 3; i++) step("peak_wr3", 1, 8'(i), 0, 0, 0);
`ifdef PIXEL_FIFO_PEAK_EN
      chk("peak:9", 32'(peak_level), 9);
`endif
      step("peak_clr", 0, 8'h00, 0, 0, 1);
`ifdef PIXEL_FIFO_PEAK_EN
      chk("peak:3", 32'(peak_level), 3);
`endif

      // Random traffic: write-heavy phase then read-heavy phase.
      for (int i = 0; i < 600; i++) begin
         bit wr, rd, fl, clr;
         int wp;
         wp = (i < 300) ? 70 : 30;
         wr  = ($urandom_range(99) < wp);
         rd  = ($urandom_range(99) < (100 - wp));
         fl  = ($urandom_range(99) < 2);
         clr = ($urandom_range(99) < 5);
         step("rand", wr, 8'($urandom), rd, fl, clr);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
